// File: rtl/hcvc_ps_pkg.sv
// Shared pixel-shuffle definitions: stream state encoding and frame geometry helpers.
// Used by both the upstream shuffle stage and the streamer.
package hcvc_ps_pkg;

    typedef enum logic {
        PS_IDLE   = 1'b0,
        PS_STREAM = 1'b1
    } ps_state_e;

    function automatic int ps_ho(input int h, input int r);
        return h * r;
    endfunction

    function automatic int ps_wo(input int w, input int r);
        return w * r;
    endfunction

    function automatic int ps_npix(input int c, input int h, input int w, input int r);
        return c * ps_ho(h, r) * ps_wo(w, r);
    endfunction

    // Counter width that stays legal for a range of one value.
    function automatic int ps_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ps_raster_counter.sv
// Channel-planar raster position counter: x fastest, then y, then c.
// clear_i wins over advance_i; after the final position all counters wrap to 0.
module ps_raster_counter
    import hcvc_ps_pkg::*;
#(
    parameter int C  = 1,
    parameter int HO = 4,
    parameter int WO = 4,
    localparam int XW = ps_cw(WO),
    localparam int YW = ps_cw(HO),
    localparam int CW = ps_cw(C)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic [CW-1:0] c_o,
    output logic          eol_o,
    output logic          eof_o
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] c_q, c_d;
    logic          x_last, y_last, c_last;

    assign x_last = (x_q == XW'(WO - 1));
    assign y_last = (y_q == YW'(HO - 1));
    assign c_last = (c_q == CW'(C - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        c_d = c_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
            c_d = '0;
        end else if (advance_i) begin
            if (x_last) begin
                x_d = '0;
                if (y_last) begin
                    y_d = '0;
                    c_d = c_last ? '0 : c_q + 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            c_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            c_q <= c_d;
        end
    end

    assign x_o   = x_q;
    assign y_o   = y_q;
    assign c_o   = c_q;
    assign eol_o = x_last;
    assign eof_o = x_last & y_last & c_last;

endmodule

// File: rtl/pixel_shuffle_streamer.sv
// Captures a whole pixel-shuffled frame and streams it pixel by pixel in (c, y, x) order.
// Optional start-of-frame flag out_sof is added when PS_STREAM_SOF_EN is defined.
module pixel_shuffle_streamer
    import hcvc_ps_pkg::*;
#(
    parameter int C          = 1,
    parameter int R          = 2,
    parameter int H          = 2,
    parameter int W          = 2,
    parameter int DATA_WIDTH = 8,
    localparam int HO   = ps_ho(H, R),
    localparam int WO   = ps_wo(W, R),
    localparam int NPIX = ps_npix(C, H, W, R)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    input  logic [NPIX*DATA_WIDTH-1:0] frame_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
`ifdef PS_STREAM_SOF_EN
    output logic                       out_sof,
`endif
    output logic                       out_eol,
    output logic                       out_eof
);

    localparam int XW = ps_cw(WO);
    localparam int YW = ps_cw(HO);
    localparam int CW = ps_cw(C);
    localparam int IW = $clog2(NPIX + 1);

    // Handshake: a beat transfers on any edge where out_valid && out_ready; the
    // beat is held unchanged otherwise. frame_ready is the capture enable in IDLE.
    ps_state_e             state_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] pix_q     [NPIX];
    logic [DATA_WIDTH-1:0] frame_arr [NPIX];
    logic [DATA_WIDTH-1:0] pix_sel;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [CW-1:0]         c;
    logic                  eol, eof;
    logic                  capture, advance;
    logic [IW-1:0]         idx;

    for (genvar g = 0; g < NPIX; g++) begin : g_unpack
        assign frame_arr[g] = frame_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign capture = (state_q == PS_IDLE) && frame_valid;
    assign advance = valid_q && out_ready;

    ps_raster_counter #(.C(C), .HO(HO), .WO(WO)) u_raster (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (capture),
        .advance_i(advance),
        .x_o      (x),
        .y_o      (y),
        .c_o      (c),
        .eol_o    (eol),
        .eof_o    (eof)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PS_IDLE;
            valid_q <= 1'b0;
            pix_q   <= '{default: '0};
        end else begin
            case (state_q)
                PS_IDLE: begin
                    if (frame_valid) begin
                        state_q <= PS_STREAM;
                        valid_q <= 1'b1;
                        pix_q   <= frame_arr;
                    end
                end
                PS_STREAM: begin
                    if (advance && eof) begin
                        state_q <= PS_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= PS_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Flat pixel index of the current raster position.
    assign idx = (IW'(c) * IW'(HO) + IW'(y)) * IW'(WO) + IW'(x);

    always_comb begin
        pix_sel = '0;
        for (int i = 0; i < NPIX; i++) begin
            if (idx == IW'(i)) pix_sel = pix_q[i];
        end
    end

    assign frame_ready = (state_q == PS_IDLE);
    assign out_valid   = valid_q;
    assign out_data    = valid_q ? pix_sel : '0;
    assign out_eol     = valid_q & eol;
    assign out_eof     = valid_q & eof;
`ifdef PS_STREAM_SOF_EN
    assign out_sof     = valid_q & (idx == '0);
`endif

endmodule

// File: tb/tb_pixel_shuffle_streamer.sv
// Self-checking bench for pixel_shuffle_streamer; covers the default frame, a
// multi-channel frame and the single-pixel frame, with and without PS_STREAM_SOF_EN.
module tb_pixel_shuffle_streamer;

  localparam int DW   = 8;
  localparam int NPIX = 16;
  localparam int WO   = 4;
  localparam int FW   = NPIX * DW;
  localparam int EW   = DW + 3;
  localparam int MAXC = 200;
`ifdef PS_STREAM_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT: C=1 R=2 H=2 W=2
  logic          frame_valid, frame_ready, out_valid, out_ready, out_eol, out_eof, sof_obs;
  logic [FW-1:0] frame_data;
  logic [DW-1:0] out_data;

  pixel_shuffle_streamer #(.C(1), .R(2), .H(2), .W(2), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef PS_STREAM_SOF_EN
    .out_sof(sof_obs),
`endif
    .out_eol(out_eol), .out_eof(out_eof)
  );

  // multi-channel DUT: C=2 R=2 H=1 W=1 -> 8 pixels, rows of 2
  logic          mc_frame_valid, mc_frame_ready, mc_out_valid, mc_out_ready, mc_out_eol, mc_out_eof, mc_sof_obs;
  logic [63:0]   mc_frame_data;
  logic [DW-1:0] mc_out_data;

  pixel_shuffle_streamer #(.C(2), .R(2), .H(1), .W(1), .DATA_WIDTH(DW)) dut_mc (
    .clk(clk), .rst(rst),
    .frame_valid(mc_frame_valid), .frame_ready(mc_frame_ready), .frame_data(mc_frame_data),
    .out_valid(mc_out_valid), .out_ready(mc_out_ready), .out_data(mc_out_data),
`ifdef PS_STREAM_SOF_EN
    .out_sof(mc_sof_obs),
`endif
    .out_eol(mc_out_eol), .out_eof(mc_out_eof)
  );

  // single-pixel DUT: C=R=H=W=1
  logic          one_frame_valid, one_frame_ready, one_out_valid, one_out_ready, one_out_eol, one_out_eof, one_sof_obs;
  logic [DW-1:0] one_frame_data, one_out_data;

  pixel_shuffle_streamer #(.C(1), .R(1), .H(1), .W(1), .DATA_WIDTH(DW)) dut_one (
    .clk(clk), .rst(rst),
    .frame_valid(one_frame_valid), .frame_ready(one_frame_ready), .frame_data(one_frame_data),
    .out_valid(one_out_valid), .out_ready(one_out_ready), .out_data(one_out_data),
`ifdef PS_STREAM_SOF_EN
    .out_sof(one_sof_obs),
`endif
    .out_eol(one_out_eol), .out_eof(one_out_eof)
  );

`ifndef PS_STREAM_SOF_EN
  assign sof_obs     = 1'b0;
  assign mc_sof_obs  = 1'b0;
  assign one_sof_obs = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  // entry = {sof, eof, eol, data}
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [FW-1:0] busy_frame;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: pixels leave in ascending flat index; a row is WO pixels wide.
  task automatic model_push(input logic [FW-1:0] f);
    logic [FW-1:0] t;
    for (int i = 0; i < NPIX; i++) begin
      t = f >> (i * DW);
      exp_q.push_back({SOF_EN && (i == 0), i == NPIX - 1, (i % WO) == WO - 1, t[DW-1:0]});
    end
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < NPIX; i++) f[i*DW +: DW] = 8'($urandom);
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [FW-1:0] f);
    int k = 0;
    while (!frame_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("capture_frame_ready", frame_ready, 1);
    frame_valid = 1'b1;
    frame_data  = f;
    model_push(f);
    @(posedge clk); #1;
    frame_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  // stop_after > 0 ends the drain once that many beats were accepted.
  task automatic drain(input int mode, input int stop_after, input bit busy);
    int k, beats;
    bit done;
    logic rdy;
    logic [EW-1:0] e;
    k = 0; beats = 0; done = 1'b0;
    if (busy) begin
      frame_valid = 1'b1;
      frame_data  = busy_frame;
    end
    while (!done && k < MAXC) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((k % 4) == 0) || ((k % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      check("stream_valid", out_valid, 1);
      check("stream_frame_ready", frame_ready, 0);
      if (out_valid) begin
        check("exp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() == 0) begin
          done = 1'b1;
        end else begin
          e = exp_q[0];
          check("beat_data", out_data, e[DW-1:0]);
          check("beat_eol", out_eol, e[DW]);
          check("beat_eof", out_eof, e[DW+1]);
          check("beat_sof", sof_obs, e[DW+2]);
          if (rdy) begin
            e = exp_q.pop_front();
            beats++;
            if (e[DW+1]) done = 1'b1;
            if (stop_after > 0 && beats == stop_after) done = 1'b1;
          end
        end
      end
      @(posedge clk); #1;
      k++;
    end
    check("drain_in_budget", done, 1);
    if (stop_after == 0) begin
      check("beat_count", beats, NPIX);
      check("end_valid", out_valid, 0);
      check("end_frame_ready", frame_ready, 1);
      check("end_eol", out_eol, 0);
      check("end_eof", out_eof, 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [FW-1:0] f;
    logic [63:0]   mf;
    logic [DW-1:0] md;

    rst = 1'b1;
    frame_valid = 1'b0; frame_data = '0; out_ready = 1'b1;
    mc_frame_valid = 1'b0; mc_frame_data = '0; mc_out_ready = 1'b1;
    one_frame_valid = 1'b0; one_frame_data = '0; one_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_frame_ready", frame_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_eol", out_eol, 0);
    check("rst_eof", out_eof, 0);
    check("rst_sof", sof_obs, 0);
    check("rst_mc_ready", mc_frame_ready, 1);
    check("rst_one_ready", one_frame_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic frame, pixel i = i, continuous ready
    for (int i = 0; i < NPIX; i++) f[i*DW +: DW] = 8'(i);
    send_frame(f);
    drain(0, 0, 1'b0);

    // backpressure pattern
    send_frame(rand_frame());
    drain(1, 0, 1'b0);

    // busy-ignore: a new frame is offered during the whole stream
    for (int i = 0; i < NPIX; i++) busy_frame[i*DW +: DW] = 8'(8'hAA + i);
    send_frame(rand_frame());
    drain(0, 0, 1'b1);
    model_push(busy_frame);
    @(posedge clk); #1;
    frame_valid = 1'b0;
    drain(0, 0, 1'b0);

    // random backpressure
    send_frame(rand_frame());
    drain(2, 0, 1'b0);

    // mid-frame reset after beat 5
    send_frame(rand_frame());
    drain(0, 6, 1'b0);
    rst = 1'b1;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_frame_ready", frame_ready, 1);
    check("mrst_data", out_data, 0);
    check("mrst_eol", out_eol, 0);
    check("mrst_eof", out_eof, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("post_rst_idle_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < NPIX; i++) f[i*DW +: DW] = 8'(8'h40 + i);
    send_frame(f);
    drain(2, 0, 1'b0);

    // multi-channel frame: 8 beats, rows of 2
    mf = {$urandom, $urandom};
    mc_frame_valid = 1'b1;
    mc_frame_data  = mf;
    @(posedge clk); #1;
    mc_frame_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      md = 8'(mf >> (i * DW));
      check("mc_valid", mc_out_valid, 1);
      check("mc_data", mc_out_data, md);
      check("mc_eol", mc_out_eol, (i % 2) == 1);
      check("mc_eof", mc_out_eof, i == 7);
      check("mc_sof", mc_sof_obs, SOF_EN && (i == 0));
      @(posedge clk); #1;
    end
    check("mc_end_valid", mc_out_valid, 0);
    check("mc_end_ready", mc_frame_ready, 1);

    // single-pixel frame
    md = 8'($urandom);
    one_frame_valid = 1'b1;
    one_frame_data  = md;
    @(posedge clk); #1;
    one_frame_valid = 1'b0;
    check("one_valid", one_out_valid, 1);
    check("one_data", one_out_data, md);
    check("one_eol", one_out_eol, 1);
    check("one_eof", one_out_eof, 1);
    check("one_sof", one_sof_obs, SOF_EN);
    check("one_busy", one_frame_ready, 0);
    @(posedge clk); #1;
    check("one_end_valid", one_out_valid, 0);
    check("one_end_ready", one_frame_ready, 1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
